// File: rtl/exe_muldiv_if.sv
// Request/response bundle between the execute stage and the exe_muldiv unit.
interface exe_muldiv_if #(
  parameter int unsigned XLEN = 64
);
  logic            START;
  logic [2:0]      FUNCT3;
  logic            WORD;
  logic [XLEN-1:0] OP_A;
  logic [XLEN-1:0] OP_B;
  logic            FLUSH;
  logic            STALL;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FUNCT3, WORD, OP_A, OP_B, FLUSH,
    input  STALL, BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FUNCT3, WORD, OP_A, OP_B, FLUSH,
    output STALL, BUSY, DONE, RESULT
  );
endinterface

// File: rtl/exe_muldiv.sv
// Multi-cycle RISC-V M-extension unit (radix-2 shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies complete combinationally in IDLE; divides stay iterative.
module exe_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input logic         clk,
  input logic         RESET,
  exe_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            is_w;
  logic            neg_q;
  logic            neg_r;
  logic            busy;
  logic            done;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   acc;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic            word_c, n32_c, is_mul_c, illegal_c, sign_a_c, sign_b_c;
  logic            na_c, nb_c, div0_c, ovf_c;
  logic [CW-1:0]   top_c;
  logic [XLEN-1:0] a_ext_c, b_ext_c, a_mag_c, b_mag_c, min_c;

  // Operand decode for the request presented in IDLE
  always_comb begin
    word_c    = (XLEN == 64) && bus.WORD;
    n32_c     = word_c || (XLEN == 32);
    is_mul_c  = !bus.FUNCT3[2];
    illegal_c = word_c && is_mul_c && (bus.FUNCT3[1:0] != 2'd0);
    sign_a_c  = (bus.FUNCT3 == 3'd1) || (bus.FUNCT3 == 3'd2) ||
                (bus.FUNCT3 == 3'd4) || (bus.FUNCT3 == 3'd6);
    sign_b_c  = (bus.FUNCT3 == 3'd1) || (bus.FUNCT3 == 3'd4) || (bus.FUNCT3 == 3'd6);
    if (word_c) begin
      a_ext_c = sign_a_c ? sext32(bus.OP_A[31:0]) : XLEN'(bus.OP_A[31:0]);
      b_ext_c = sign_b_c ? sext32(bus.OP_B[31:0]) : XLEN'(bus.OP_B[31:0]);
    end else begin
      a_ext_c = bus.OP_A;
      b_ext_c = bus.OP_B;
    end
    na_c    = sign_a_c && a_ext_c[XLEN-1];
    nb_c    = sign_b_c && b_ext_c[XLEN-1];
    a_mag_c = na_c ? -a_ext_c : a_ext_c;
    b_mag_c = nb_c ? -b_ext_c : b_ext_c;
    top_c   = n32_c ? CW'(31) : CW'(XLEN - 1);
    min_c   = ~((XLEN'(1) << top_c) - XLEN'(1));
    div0_c  = !is_mul_c && (b_ext_c == '0);
    ovf_c   = !is_mul_c && !bus.FUNCT3[0] && (a_ext_c == min_c) && (&b_ext_c);
  end

  logic [CW-1:0] idx_c;
  logic [XLEN:0] rem_sh_c;
  logic          qbit_c;

  // One restoring-divide step on the next dividend bit
  always_comb begin
    idx_c    = cnt - CW'(1);
    rem_sh_c = {rem, a_mag[idx_c]};
    qbit_c   = rem_sh_c >= {1'b0, b_mag};
  end

  logic [AW-1:0]   q_fix_c;
  logic [XLEN-1:0] r_fix_c, sel_c, res_c;

  // Sign correction and result selection
  always_comb begin
    q_fix_c = neg_q ? -acc : acc;
    r_fix_c = neg_r ? -rem : rem;
    if (!op[2] && (op[1:0] != 2'd0)) begin
      sel_c = q_fix_c[AW-1:XLEN];
    end else if (op[2] && op[1]) begin
      sel_c = r_fix_c;
    end else begin
      sel_c = q_fix_c[XLEN-1:0];
    end
    res_c = is_w ? sext32(sel_c[31:0]) : sel_c;
  end

  // The first iteration is folded into the operand latch, so CALC runs N-1 cycles
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      op     <= '0;
      is_w   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      rem    <= '0;
      result <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      if (bus.FLUSH) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.START) begin
              op    <= bus.FUNCT3;
              is_w  <= word_c;
              a_mag <= a_mag_c;
              b_mag <= b_mag_c;
              neg_q <= na_c ^ nb_c;
              neg_r <= na_c;
              cnt   <= top_c;
              busy  <= 1'b1;
              rem   <= '0;
              acc   <= '0;
              if (illegal_c) begin
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= FIX;
              end else if (div0_c) begin
                acc   <= AW'({XLEN{1'b1}});
                rem   <= a_ext_c;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= FIX;
              end else if (ovf_c) begin
                acc   <= AW'(a_ext_c);
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= FIX;
              end else if (is_mul_c) begin
`ifdef MULDIV_FAST_MUL_EN
                acc   <= AW'(a_mag_c) * AW'(b_mag_c);
                state <= FIX;
`else
                acc   <= b_mag_c[top_c] ? AW'(a_mag_c) : '0;
                state <= CALC;
`endif
              end else begin
                acc   <= AW'(a_mag_c[top_c] && (b_mag_c == XLEN'(1)));
                rem   <= XLEN'(a_mag_c[top_c] && (b_mag_c != XLEN'(1)));
                state <= CALC;
              end
            end
          end
          CALC: begin
            if (op[2]) begin
              acc <= {acc[AW-2:0], qbit_c};
              rem <= qbit_c ? XLEN'(rem_sh_c - {1'b0, b_mag}) : rem_sh_c[XLEN-1:0];
            end else begin
              acc <= (acc << 1) + (b_mag[idx_c] ? AW'(a_mag) : '0);
            end
            cnt <= idx_c;
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            result <= res_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.STALL  = (bus.START && (state == IDLE) && !bus.FLUSH) || (state != IDLE);
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.RESULT = result;
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv (XLEN=64): results, latency, STALL, flush, back-to-back, reset.
module tb_exe_muldiv;
  localparam int unsigned XLEN = 64;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
  localparam int MULW_LAT = 2;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exe_muldiv_if #(.XLEN(XLEN)) bus ();
  exe_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .RESET(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.START  = 1'b1;
    bus.FUNCT3 = f3;
    bus.WORD   = w;
    bus.OP_A   = a;
    bus.OP_B   = b;
  endtask

  // Completes an issued request: counts edges to DONE and cycles with STALL high
  task automatic finish_op(output logic [63:0] res, output int lat, output int stl);
    #1;
    stl = bus.STALL ? 1 : 0;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    lat = 1;
    while (!bus.DONE && lat < 200) begin
      if (bus.STALL) stl++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.RESULT;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int stl);
    @(negedge clk);
    issue(f3, w, a, b);
    finish_op(res, lat, stl);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] res;
    int          lat;
    int          stl;
    int          pulses;

    checks   = 0;
    failures = 0;
    vecs[0]  = '{"div_m7_2",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[1]  = '{"rem_m7_2",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[2]  = '{"divu_5_0",    3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[3]  = '{"remu_5_0",    3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 2};
    vecs[4]  = '{"div_ovf",     3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[5]  = '{"rem_ovf",     3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[6]  = '{"mulh_m1_m1",  3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, MUL_LAT};
    vecs[7]  = '{"mulhu_max",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT};
    vecs[8]  = '{"divw_m8_2",   3'd4, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33};
    vecs[9]  = '{"mulw_max_2",  3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT};
    vecs[10] = '{"mul_6_m7",    3'd0, 1'b0, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, MUL_LAT};
    vecs[11] = '{"mulhsu_m1_2", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT};
    vecs[12] = '{"remw_m7_2",   3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[13] = '{"mulhw_illeg", 3'd1, 1'b1, 64'd3, 64'd5, 64'd0, 2};
    vecs[14] = '{"divu_100_7",  3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};

    rst        = 1'b1;
    bus.START  = 1'b0;
    bus.FUNCT3 = 3'd0;
    bus.WORD   = 1'b0;
    bus.OP_A   = '0;
    bus.OP_B   = '0;
    bus.FLUSH  = 1'b0;
    #12;
    check("rst_busy",   64'(bus.BUSY),  64'd0);
    check("rst_done",   64'(bus.DONE),  64'd0);
    check("rst_result", bus.RESULT,     64'd0);
    check("rst_stall",  64'(bus.STALL), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, res, lat, stl);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_stall_cycles"}, 64'(stl), 64'(vecs[i].lat));
      check({vecs[i].name, "_stall_in_done"}, 64'(bus.STALL), 64'd0);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, 64'(bus.DONE), 64'd0);
      check({vecs[i].name, "_result_hold"}, bus.RESULT, vecs[i].exp);
    end

    // Back-to-back: second request issued in the DONE cycle of the first
    run_op(3'd5, 1'b0, 64'd5, 64'd0, res, lat, stl);
    check("b2b_first_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    #1;
    check("b2b_stall_in_done", 64'(bus.STALL), 64'd1);
    finish_op(res, lat, stl);
    check("b2b_second_result", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check("b2b_second_latency", 64'(lat), 64'd65);

    // Flush mid-CALC: no DONE, RESULT keeps its prior value
    run_op(3'd5, 1'b0, 64'd100, 64'd7, res, lat, stl);
    check("pre_flush_result", res, 64'd14);
    @(negedge clk);
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.FLUSH = 1'b1;
    @(posedge clk);
    #1;
    bus.FLUSH = 1'b0;
    check("flush_busy",   64'(bus.BUSY), 64'd0);
    check("flush_done",   64'(bus.DONE), 64'd0);
    check("flush_result", bus.RESULT,    64'd14);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'd0);

    // FLUSH overrides a simultaneous START
    @(negedge clk);
    issue(3'd5, 1'b0, 64'd9, 64'd3);
    bus.FLUSH = 1'b1;
    #1;
    check("flush_start_stall", 64'(bus.STALL), 64'd0);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    check("flush_start_busy", 64'(bus.BUSY), 64'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy",   64'(bus.BUSY),  64'd0);
    check("rst_mid_done",   64'(bus.DONE),  64'd0);
    check("rst_mid_result", bus.RESULT,     64'd0);
    check("rst_mid_stall",  64'(bus.STALL), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) pulses++;
    end
    check("rst_no_resume", 64'(pulses), 64'd0);
    check("rst_result_stays", bus.RESULT, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
